// File: rtl/memory_pkg.sv
// Shared types and helpers for the single-port pipelined SRAM model.
package memory_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned MAX_RD_LAT     = 4;
  localparam int unsigned MAX_DATA_WIDTH = 64;

  // Bit-masked merge of a new word into an old one (1 in mask = take new bit).
  function automatic logic [MAX_DATA_WIDTH-1:0] masked_write(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_DATA_WIDTH-1:0] mask
  );
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/memory_if.sv
// Access bus of the single-port SRAM: requests from the master, read data/status back.
interface memory_if #(
  parameter int unsigned pADDR_WIDTH = 4,
  parameter int unsigned pDATA_WIDTH = 8
);
  logic                   cs;
  logic                   we;
  logic [pADDR_WIDTH-1:0] addr;
  logic [pDATA_WIDTH-1:0] din;
  logic [pDATA_WIDTH-1:0] wmask;
  logic [pDATA_WIDTH-1:0] dout;
  logic                   rvalid;
  logic                   busy;

  modport master (
    output cs, we, addr, din, wmask,
    input  dout, rvalid, busy
  );

  modport slave (
    input  cs, we, addr, din, wmask,
    output dout, rvalid, busy
  );
endinterface

// File: rtl/memory_rd_pipe.sv
// Read data/valid shift register; the last stage is the memory's dout/rvalid and holds data between reads.
module memory_rd_pipe #(
  parameter int unsigned pDATA_WIDTH = 8,
  parameter int unsigned pDEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic [pDATA_WIDTH-1:0] rd_data,
  output logic [pDATA_WIDTH-1:0] dout,
  output logic                   rvalid
);

  logic [pDATA_WIDTH-1:0] data_q [pDEPTH];
  logic [pDEPTH-1:0]      vld_q;

  // Stages only load when valid data arrives, so the final stage holds the last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(pDEPTH); i++) data_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      if (rd_en) data_q[0] <= rd_data;
      for (int i = 1; i < int'(pDEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign dout   = data_q[pDEPTH-1];
  assign rvalid = vld_q[pDEPTH-1];

endmodule

// File: rtl/memory_sp_pipe.sv
// Single-port SRAM model with bit write mask, pipelined reads and a post-reset init sequencer.
// Define MEMORY_FAULT_INJECT_EN to add a stuck-at bit (pFAULT_ADDR/pFAULT_BIT/pFAULT_VAL).
module memory_sp_pipe
  import memory_pkg::*;
#(
  parameter int unsigned            pADDR_WIDTH = 4,
  parameter int unsigned            pDATA_WIDTH = 8,
  parameter int unsigned            pRD_LAT     = 2,
  parameter logic [pDATA_WIDTH-1:0] pINIT_VAL   = '0
`ifdef MEMORY_FAULT_INJECT_EN
  ,
  parameter int unsigned            pFAULT_ADDR = 5,
  parameter int unsigned            pFAULT_BIT  = 1,
  parameter bit                     pFAULT_VAL  = 1'b1
`endif
) (
  input logic      clk,
  input logic      rst,
  memory_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << pADDR_WIDTH;

  if (pRD_LAT < 1 || pRD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $error("memory_sp_pipe: pRD_LAT must be in 1..4");
  end
  if (pDATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
    $error("memory_sp_pipe: pDATA_WIDTH exceeds MAX_DATA_WIDTH");
  end

  state_e                 state_q, state_d;
  logic [pADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                   busy_q;
  logic                   init_we_c;
  logic                   wr_acc_c;
  logic                   rd_acc_c;
  logic [pDATA_WIDTH-1:0] merged_c;
  logic [pDATA_WIDTH-1:0] init_word_c;
  logic [pDATA_WIDTH-1:0] wr_word_c;
  logic [pDATA_WIDTH-1:0] rd_word_c;
  logic [pDATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == INIT);
    end
  end

  // Init walks every address once, then hands the array over to the bus.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_c = 1'b0;
    case (state_q)
      INIT: begin
        init_we_c = 1'b1;
        cnt_d     = cnt_q + pADDR_WIDTH'(1);
        if (cnt_q == pADDR_WIDTH'(DEPTH - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign wr_acc_c = bus.cs & bus.we & ~busy_q & ~rst;
  assign rd_acc_c = bus.cs & ~bus.we & ~busy_q & ~rst;

  assign merged_c = pDATA_WIDTH'(masked_write(MAX_DATA_WIDTH'(mem[bus.addr]),
                                              MAX_DATA_WIDTH'(bus.din),
                                              MAX_DATA_WIDTH'(bus.wmask)));

`ifdef MEMORY_FAULT_INJECT_EN
  function automatic logic [pDATA_WIDTH-1:0] stuck(
    input logic [pADDR_WIDTH-1:0] a,
    input logic [pDATA_WIDTH-1:0] w
  );
    logic [pDATA_WIDTH-1:0] r;
    r = w;
    if (a == pADDR_WIDTH'(pFAULT_ADDR)) r[pFAULT_BIT] = pFAULT_VAL;
    return r;
  endfunction

  assign init_word_c = stuck(cnt_q, pINIT_VAL);
  assign wr_word_c   = stuck(bus.addr, merged_c);
  assign rd_word_c   = stuck(bus.addr, mem[bus.addr]);
`else
  assign init_word_c = pINIT_VAL;
  assign wr_word_c   = merged_c;
  assign rd_word_c   = mem[bus.addr];
`endif

  // Array has no reset; only the init sequencer or an accepted masked write change it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we_c) begin
        mem[cnt_q] <= init_word_c;
      end else if (wr_acc_c && (|bus.wmask)) begin
        mem[bus.addr] <= wr_word_c;
      end
    end
  end

  memory_rd_pipe #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pDEPTH      (pRD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_acc_c),
    .rd_data (rd_word_c),
    .dout    (bus.dout),
    .rvalid  (bus.rvalid)
  );

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_memory_sp_pipe.sv
// Directed self-checking bench for memory_sp_pipe at default parameters (depth 16, 8 bits, latency 2).
module tb_memory_sp_pipe;

  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  memory_if #(.pADDR_WIDTH(4), .pDATA_WIDTH(8)) bus ();

  memory_sp_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected stored value, accounting for the stuck bit when fault injection is built in.
  function automatic logic [7:0] exp_word(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
`ifdef MEMORY_FAULT_INJECT_EN
    if (a == 5) r[1] = 1'b1;
`endif
    return r;
  endfunction

  task automatic drive_idle();
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0; bus.wmask = '0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d; bus.wmask = m;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
  endtask

  // Called at a negedge; returns once the read should have completed.
  task automatic do_read(input logic [3:0] a, output logic [7:0] d, output bit timing_ok);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a; bus.din = '0; bus.wmask = '0;
    @(posedge clk);
    timing_ok = 1'b1;
    for (int k = 0; k < int'(LAT); k++) begin
      @(negedge clk);
      if (k == 0) drive_idle();
      if (bus.rvalid !== (k == int'(LAT) - 1)) timing_ok = 1'b0;
    end
    d = bus.dout;
  endtask

  task automatic wait_init(input string name);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (bus.busy !== 1'b1) $display("FAIL %s busy_high[%0d]: got %b want 1", name, i, bus.busy);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL %s busy_drop: got %b want 0", name, bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus.busy); else n_pass++;
    n_total++;
    if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); else n_pass++;
    n_total++;
    if (bus.dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", bus.dout); else n_pass++;
    wait_init("reset");
  endtask

  task automatic test_init_contents();
    logic [7:0] d;
    bit         ok;
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), d, ok);
      n_total++;
      if (!ok) $display("FAIL init_rd_timing[%0d]: rvalid not exactly %0d cycles", a, LAT); else n_pass++;
      n_total++;
      if (d !== exp_word(a, 8'h00)) $display("FAIL init_rd_data[%0d]: got %h want %h", a, d, exp_word(a, 8'h00));
      else n_pass++;
    end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    logic [7:0] dout_before;
    bit         ok;
    do_write(4'd3, 8'hA5, 8'hFF);
    dout_before = bus.dout;
    do_write(4'd3, 8'hFF, 8'h0F);
    n_total++;
    if (bus.rvalid !== 1'b0 || bus.dout !== dout_before)
      $display("FAIL write_no_rvalid: rvalid %b dout %h want 0 %h", bus.rvalid, bus.dout, dout_before);
    else n_pass++;
    do_read(4'd3, d, ok);
    n_total++;
    if (!ok || d !== 8'hAF) $display("FAIL mask_merge: got %h ok %b want AF", d, ok); else n_pass++;
    do_write(4'd3, 8'h00, 8'h00);
    do_read(4'd3, d, ok);
    n_total++;
    if (!ok || d !== 8'hAF) $display("FAIL mask_zero: got %h ok %b want AF", d, ok); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [20];
    int         got_cyc [20];
    int         n = 0;
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'(a * 8'h11), 8'hFF);
    for (int c = 0; c < 16 + 4; c++) begin
      if (c < 16) begin
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 4'(c);
      end else begin
        drive_idle();
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.rvalid === 1'b1 && n < 20) begin
        got[n] = bus.dout; got_cyc[n] = c; n++;
      end
    end
    n_total++;
    if (n !== 16) $display("FAIL b2b_count: got %0d want 16", n); else n_pass++;
    for (int k = 0; k < 16 && k < n; k++) begin
      n_total++;
      if (got[k] !== exp_word(k, 8'(k * 8'h11)) || got_cyc[k] !== k + int'(LAT) - 1)
        $display("FAIL b2b_read[%0d]: got %h at %0d want %h at %0d", k, got[k], got_cyc[k],
                 exp_word(k, 8'(k * 8'h11)), k + int'(LAT) - 1);
      else n_pass++;
    end
    n_total++;
    if (bus.dout !== 8'hFF || bus.rvalid !== 1'b0)
      $display("FAIL b2b_hold: dout %h rvalid %b want FF 0", bus.dout, bus.rvalid);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    logic [7:0] d;
    bit         ok;
    do_write(4'd7, 8'h3C, 8'hFF);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 4'd7;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.rvalid !== 1'b0 || bus.dout !== 8'h00)
      $display("FAIL inflight_drop: rvalid %b dout %h want 0 00", bus.rvalid, bus.dout);
    else n_pass++;
    @(negedge clk);
    wait_init("inflight");
    do_read(4'd7, d, ok);
    n_total++;
    if (!ok || d !== 8'h00) $display("FAIL inflight_reinit: got %h ok %b want 00", d, ok); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d;
    bit         ok;
    bit         saw_rvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 4'd2; bus.din = 8'h55; bus.wmask = 8'hFF;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.rvalid === 1'b1) saw_rvalid = 1'b1;
      if (i == 7) bus.we = 1'b0;
      if (i == 10) bus.we = 1'b1;
    end
    drive_idle();
    n_total++;
    if (bus.busy !== 1'b0 || saw_rvalid)
      $display("FAIL busy_window: busy %b rvalid_seen %b want 0 0", bus.busy, saw_rvalid);
    else n_pass++;
    do_read(4'd2, d, ok);
    n_total++;
    if (!ok || d !== 8'h00) $display("FAIL busy_ignore: got %h ok %b want 00", d, ok); else n_pass++;
  endtask

  task automatic test_fault();
    logic [7:0] d;
    bit         ok;
    do_write(4'd5, 8'h00, 8'hFF);
    do_read(4'd5, d, ok);
    n_total++;
    if (!ok || d !== exp_word(5, 8'h00)) $display("FAIL fault_addr5: got %h want %h", d, exp_word(5, 8'h00));
    else n_pass++;
    do_write(4'd4, 8'h00, 8'hFF);
    do_read(4'd4, d, ok);
    n_total++;
    if (!ok || d !== 8'h00) $display("FAIL fault_addr4: got %h want 00", d); else n_pass++;
  endtask

  initial begin
    drive_idle();
    @(negedge clk);
    test_reset();
    test_init_contents();
    test_mask();
    test_back_to_back();
    test_reset_inflight();
    test_busy_ignore();
    test_fault();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
